// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the single-cycle core.
//   Combinational word read at addr[log2(DEPTH_WORDS)+1:2]; clocked byte-lane
//   stores (byte/half/word, right-aligned store data); sticky misaligned-store
//   flag. With DMEM_MMIO_EN defined, a 16-byte MMIO window at MMIO_BASE holds
//   a free-running CYCLE counter, a TXDATA push port into an 8-bit console
//   FIFO, a STATUS register and a CTRL register that clears ovf/err.
// Optional feature macro: DMEM_MMIO_EN
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high
//   addr      in   [31:0] byte address
//   wdata     in   [31:0] store data, right-aligned
//   MemWrite  in   [1:0]  00 none, 01 byte, 10 half, 11 word
//   rdata     out  [31:0] aligned word (or MMIO register) at addr
//   tx_data   out  [7:0]  FIFO head byte
//   tx_valid  out  FIFO non-empty
//   tx_ready  in   consumer takes the head this cycle
//   err       out  sticky misaligned-store flag
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  MemWrite,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_HALF: return a[0];
            SZ_WORD: return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 4'b0001 << a;
            SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the right-aligned store data across lanes so the lane mask
    // alone selects what lands where.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic          store;
    logic          store_bad;
    logic          store_ok;
    logic          in_win;
    logic          ram_we;
    logic          ctrl_clr;
    logic [3:0]    lanes;
    logic [31:0]   wlane;

    assign word_idx  = addr[AW+1:2];
    assign store     = MemWrite != SZ_NONE;
    assign store_bad = store && is_misaligned(MemWrite, addr[1:0]);
    // A store in the reset cycle is dropped entirely.
    assign store_ok  = store && !store_bad && !reset;
    assign ram_we    = store_ok && !in_win;
    assign lanes     = lane_mask(MemWrite, addr[1:0]);
    assign wlane     = lane_data(MemWrite, wdata);

    // RAM is never reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) mem[word_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (store_bad) begin
            err <= 1'b1;
        end else if (ctrl_clr) begin
            err <= 1'b0;
        end
    end

`ifdef DMEM_MMIO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   cycle_cnt;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic          ovf;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push_acc;
    logic          pop;
    logic [31:0]   status;

    assign in_win     = addr[31:4] == MMIO_BASE[31:4];
    assign fifo_full  = fifo_count == CW'(FIFO_DEPTH);
    assign fifo_empty = fifo_count == '0;
    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo_mem[rd_ptr];
    assign pop        = tx_valid && tx_ready;
    assign push_req   = store_ok && in_win && addr[3:2] == 2'd1;
    // A pop in the same cycle frees the slot the push needs.
    assign push_acc   = push_req && (!fifo_full || pop);
    assign ctrl_clr   = store_ok && in_win && addr[3:2] == 2'd3 && wdata[0];
    assign status     = {16'd0, 8'(fifo_count), 4'd0, err, ovf, fifo_empty, fifo_full};

    always_ff @(posedge clk) begin
        if (push_acc) fifo_mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf        <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (push_acc) wr_ptr <= wr_ptr + PW'(1);
            if (pop)      rd_ptr <= rd_ptr + PW'(1);
            case ({push_acc, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && !push_acc) begin
                ovf <= 1'b1;
            end else if (ctrl_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = mem[word_idx];
        if (in_win) begin
            case (addr[3:2])
                2'd0:    rdata = cycle_cnt;
                2'd2:    rdata = status;
                default: rdata = '0;
            endcase
        end
    end
`else
    logic unused_inputs;

    assign in_win        = 1'b0;
    assign ctrl_clr      = 1'b0;
    assign tx_valid      = 1'b0;
    assign tx_data       = 8'd0;
    assign rdata         = mem[word_idx];
    assign unused_inputs = ^{tx_ready, addr[31:AW+2]};
`endif

endmodule
